// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolver
// Purpose  : Resolution end of the branch-prediction loop. Each fetched
//            branch is recorded with its predicted direction in an in-order
//            pending queue. When execute resolves the oldest branch, the
//            actual outcome is compared with the prediction. A registered
//            one-cycle update is then sent back to the predictor. A
//            mismatch also produces a flush and the corrected redirect PC.
// Ports    : clk, rst (sync, active-high), en (pipeline advance)
//            push/push_taken/push_target/push_fallthrough : fetch side
//            resolve/resolve_taken                        : execute side
//            branch/misprediction/flush/redirect_pc       : update pulses
//            count/full/empty/overflow/underflow          : queue status
//            total_branches/total_mispredictions          : saturating stats
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolver #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    push,
    input  logic                    push_taken,
    input  logic [ADDR_WIDTH-1:0]   push_target,
    input  logic [ADDR_WIDTH-1:0]   push_fallthrough,
    input  logic                    resolve,
    input  logic                    resolve_taken,
    output logic                    branch,
    output logic                    misprediction,
    output logic                    flush,
    output logic [ADDR_WIDTH-1:0]   redirect_pc,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    output logic                    underflow,
    output logic [CNT_WIDTH-1:0]    total_branches,
    output logic [CNT_WIDTH-1:0]    total_mispredictions
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    // Queue storage; contents are don't-care after reset, so no reset here.
    logic                  r_q_taken [DEPTH];
    logic [ADDR_WIDTH-1:0] r_q_target [DEPTH];
    logic [ADDR_WIDTH-1:0] r_q_fall [DEPTH];

    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_branch;
    logic                  r_mispred;
    logic [ADDR_WIDTH-1:0] r_redirect_pc;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [CNT_WIDTH-1:0]  r_tot_br;
    logic [CNT_WIDTH-1:0]  r_tot_mp;

    logic w_full;
    logic w_empty;
    logic w_res_acc;
    logic w_mismatch;
    logic w_push_acc;
    logic w_push_drop;

    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_empty   = (r_count == '0);
    assign w_res_acc = en & resolve & ~w_empty;
    assign w_mismatch = w_res_acc & (r_q_taken[r_rd_ptr] != resolve_taken);
    // A full queue still accepts a push when the head retires in the same
    // cycle; any push in a mispredicting cycle is wrong-path and discarded.
    assign w_push_acc  = en & push & (~w_full | w_res_acc) & ~w_mismatch;
    // Overflow only counts pushes lost to lack of space, not flush kills.
    assign w_push_drop = en & push & w_full & ~w_res_acc;

    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_q_taken[r_wr_ptr]  <= push_taken;
            r_q_target[r_wr_ptr] <= push_target;
            r_q_fall[r_wr_ptr]   <= push_fallthrough;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_branch      <= 1'b0;
            r_mispred     <= 1'b0;
            r_redirect_pc <= '0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_tot_br      <= '0;
            r_tot_mp      <= '0;
        end else begin
            // Pulses follow the accepted resolve; en = 0 forces them low.
            r_branch  <= w_res_acc;
            r_mispred <= w_mismatch;

            if (w_push_drop) begin
                r_overflow <= 1'b1;
            end
            if (en & resolve & w_empty) begin
                r_underflow <= 1'b1;
            end

            if (w_mismatch) begin
                // Everything younger than the head is wrong-path: drop it all.
                r_count       <= '0;
                r_rd_ptr      <= r_wr_ptr;
                r_redirect_pc <= resolve_taken ? r_q_target[r_rd_ptr]
                                               : r_q_fall[r_rd_ptr];
            end else begin
                if (w_res_acc) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                if (w_push_acc) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                r_count <= r_count + c_CNT_W'(w_push_acc) - c_CNT_W'(w_res_acc);
            end

            if (w_res_acc && (r_tot_br != '1)) begin
                r_tot_br <= r_tot_br + CNT_WIDTH'(1);
            end
            if (w_mismatch && (r_tot_mp != '1)) begin
                r_tot_mp <= r_tot_mp + CNT_WIDTH'(1);
            end
        end
    end

    assign branch               = r_branch;
    assign misprediction        = r_mispred;
    assign flush                = r_mispred;
    assign redirect_pc          = r_redirect_pc;
    assign count                = r_count;
    assign full                 = w_full;
    assign empty                = w_empty;
    assign overflow             = r_overflow;
    assign underflow            = r_underflow;
    assign total_branches       = r_tot_br;
    assign total_mispredictions = r_tot_mp;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolver
// Purpose  : Directed, table-driven bench for branch_resolver. A second
//            instance with 2-bit statistics counters shares the stimulus.
//            Its counters must read the clamped totals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst, en, push, push_taken, resolve, resolve_taken;
    logic [31:0] push_target, push_fallthrough;

    logic        branch, misprediction, flush, full, empty, overflow, underflow;
    logic [31:0] redirect_pc;
    logic [2:0]  count;
    logic [15:0] total_branches, total_mispredictions;

    logic        s_branch, s_mispred, s_flush, s_full, s_empty, s_ovf, s_unf;
    logic [31:0] s_rpc;
    logic [2:0]  s_count;
    logic [1:0]  s_tb, s_tm;

    always #5 clk = ~clk;

    branch_resolver #(.DEPTH(4), .ADDR_WIDTH(32), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .push(push), .push_taken(push_taken),
        .push_target(push_target), .push_fallthrough(push_fallthrough),
        .resolve(resolve), .resolve_taken(resolve_taken),
        .branch(branch), .misprediction(misprediction), .flush(flush),
        .redirect_pc(redirect_pc), .count(count), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow),
        .total_branches(total_branches),
        .total_mispredictions(total_mispredictions)
    );

    branch_resolver #(.DEPTH(4), .ADDR_WIDTH(32), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .push(push), .push_taken(push_taken),
        .push_target(push_target), .push_fallthrough(push_fallthrough),
        .resolve(resolve), .resolve_taken(resolve_taken),
        .branch(s_branch), .misprediction(s_mispred), .flush(s_flush),
        .redirect_pc(s_rpc), .count(s_count), .full(s_full), .empty(s_empty),
        .overflow(s_ovf), .underflow(s_unf),
        .total_branches(s_tb), .total_mispredictions(s_tm)
    );

    typedef struct {
        logic        rst, en, push, pt;
        logic [31:0] tgt, ft;
        logic        res, rt;
        logic        br, mp;
        logic [31:0] rpc;
        logic [2:0]  cnt;
        logic        ovf, unf;
        logic [15:0] tb, tm;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(
        input logic r, input logic e, input logic p, input logic pt,
        input logic [31:0] tgt, input logic [31:0] ft,
        input logic rs, input logic rt,
        input logic br, input logic mp, input logic [31:0] rpc,
        input logic [2:0] cnt, input logic ovf, input logic unf,
        input logic [15:0] tb, input logic [15:0] tm);
        vec_t v;
        v.rst = r; v.en = e; v.push = p; v.pt = pt; v.tgt = tgt; v.ft = ft;
        v.res = rs; v.rt = rt; v.br = br; v.mp = mp; v.rpc = rpc; v.cnt = cnt;
        v.ovf = ovf; v.unf = unf; v.tb = tb; v.tm = tm;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [15:0] sat_tb, sat_tm;
        @(negedge clk);
        rst = v.rst; en = v.en; push = v.push; push_taken = v.pt;
        push_target = v.tgt; push_fallthrough = v.ft;
        resolve = v.res; resolve_taken = v.rt;
        @(posedge clk);
        #1;
        sat_tb = (v.tb > 16'd3) ? 16'd3 : v.tb;
        sat_tm = (v.tm > 16'd3) ? 16'd3 : v.tm;
        chk("branch",        idx, 32'(branch),         32'(v.br));
        chk("misprediction", idx, 32'(misprediction),  32'(v.mp));
        chk("flush",         idx, 32'(flush),          32'(v.mp));
        chk("redirect_pc",   idx, redirect_pc,         v.rpc);
        chk("count",         idx, 32'(count),          32'(v.cnt));
        chk("full",          idx, 32'(full),           32'(v.cnt == 3'd4));
        chk("empty",         idx, 32'(empty),          32'(v.cnt == 3'd0));
        chk("overflow",      idx, 32'(overflow),       32'(v.ovf));
        chk("underflow",     idx, 32'(underflow),      32'(v.unf));
        chk("total_br",      idx, 32'(total_branches), 32'(v.tb));
        chk("total_mp",      idx, 32'(total_mispredictions), 32'(v.tm));
        chk("sat_total_br",  idx, 32'(s_tb),           32'(sat_tb));
        chk("sat_total_mp",  idx, 32'(s_tm),           32'(sat_tm));
    endtask

    vec_t tbl [38];

    initial begin
        rst = 1'b1; en = 1'b0; push = 1'b0; push_taken = 1'b0;
        push_target = '0; push_fallthrough = '0; resolve = 1'b0; resolve_taken = 1'b0;

        //           rst en ps pt  tgt      ft       rs rt | br mp rpc      cnt ovf unf tb tm
        tbl[0]  = mk(1, 1, 0, 0, 32'h0,   32'h0,   0, 0,   0, 0, 32'h0,   0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 1, 32'h10,  32'h14,  0, 0,   0, 0, 32'h0,   1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 0, 32'h20,  32'h24,  0, 0,   0, 0, 32'h0,   2, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 1, 1, 32'h30,  32'h34,  0, 0,   0, 0, 32'h0,   3, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 32'h0,   32'h0,   1, 1,   1, 0, 32'h0,   2, 0, 0, 1, 0);
        tbl[5]  = mk(0, 1, 0, 0, 32'h0,   32'h0,   1, 0,   1, 0, 32'h0,   1, 0, 0, 2, 0);
        tbl[6]  = mk(0, 1, 0, 0, 32'h0,   32'h0,   1, 1,   1, 0, 32'h0,   0, 0, 0, 3, 0);
        tbl[7]  = mk(0, 1, 0, 0, 32'h0,   32'h0,   0, 0,   0, 0, 32'h0,   0, 0, 0, 3, 0);
        // Mispredict on a not-taken outcome: redirect to fallthrough, flush all.
        tbl[8]  = mk(0, 1, 1, 1, 32'h100, 32'h204, 0, 0,   0, 0, 32'h0,   1, 0, 0, 3, 0);
        tbl[9]  = mk(0, 1, 1, 0, 32'h200, 32'h304, 0, 0,   0, 0, 32'h0,   2, 0, 0, 3, 0);
        tbl[10] = mk(0, 1, 1, 1, 32'h300, 32'h404, 0, 0,   0, 0, 32'h0,   3, 0, 0, 3, 0);
        tbl[11] = mk(0, 1, 0, 0, 32'h0,   32'h0,   1, 0,   1, 1, 32'h204, 0, 0, 0, 4, 1);
        tbl[12] = mk(0, 1, 0, 0, 32'h0,   32'h0,   0, 0,   0, 0, 32'h204, 0, 0, 0, 4, 1);
        // Fill, then push + correct resolve while full, then push alone.
        tbl[13] = mk(0, 1, 1, 0, 32'h500, 32'h504, 0, 0,   0, 0, 32'h204, 1, 0, 0, 4, 1);
        tbl[14] = mk(0, 1, 1, 1, 32'h600, 32'h604, 0, 0,   0, 0, 32'h204, 2, 0, 0, 4, 1);
        tbl[15] = mk(0, 1, 1, 0, 32'h700, 32'h704, 0, 0,   0, 0, 32'h204, 3, 0, 0, 4, 1);
        tbl[16] = mk(0, 1, 1, 1, 32'h800, 32'h804, 0, 0,   0, 0, 32'h204, 4, 0, 0, 4, 1);
        tbl[17] = mk(0, 1, 1, 0, 32'h900, 32'h904, 1, 0,   1, 0, 32'h204, 4, 0, 0, 5, 1);
        tbl[18] = mk(0, 1, 1, 1, 32'hA00, 32'hA04, 0, 0,   0, 0, 32'h204, 4, 1, 0, 5, 1);
        // Full, mispredict with a push in the same cycle: push is killed.
        tbl[19] = mk(0, 1, 1, 1, 32'hB00, 32'hB04, 1, 0,   1, 1, 32'h604, 0, 1, 0, 6, 2);
        tbl[20] = mk(0, 1, 0, 0, 32'h0,   32'h0,   1, 1,   0, 0, 32'h604, 0, 1, 1, 6, 2);
        tbl[21] = mk(0, 0, 1, 1, 32'hC0,  32'hC4,  1, 1,   0, 0, 32'h604, 0, 1, 1, 6, 2);
        tbl[22] = mk(0, 0, 1, 0, 32'hC0,  32'hC4,  1, 0,   0, 0, 32'h604, 0, 1, 1, 6, 2);
        tbl[23] = mk(0, 0, 1, 1, 32'hC0,  32'hC4,  1, 1,   0, 0, 32'h604, 0, 1, 1, 6, 2);
        // Mispredict on a taken outcome: redirect to target; en=0 holds first.
        tbl[24] = mk(0, 1, 1, 0, 32'hC00, 32'hC04, 0, 0,   0, 0, 32'h604, 1, 1, 1, 6, 2);
        tbl[25] = mk(0, 0, 0, 0, 32'h0,   32'h0,   1, 1,   0, 0, 32'h604, 1, 1, 1, 6, 2);
        tbl[26] = mk(0, 1, 0, 0, 32'h0,   32'h0,   1, 1,   1, 1, 32'hC00, 0, 1, 1, 7, 3);
        tbl[27] = mk(0, 1, 1, 0, 32'hD00, 32'hD04, 0, 0,   0, 0, 32'hC00, 1, 1, 1, 7, 3);
        tbl[28] = mk(0, 1, 1, 1, 32'hE00, 32'hE04, 1, 1,   1, 1, 32'hD00, 0, 1, 1, 8, 4);
        tbl[29] = mk(0, 1, 0, 0, 32'h0,   32'h0,   0, 0,   0, 0, 32'hD00, 0, 1, 1, 8, 4);
        tbl[30] = mk(0, 1, 1, 1, 32'hF00, 32'hF04, 0, 0,   0, 0, 32'hD00, 1, 1, 1, 8, 4);
        tbl[31] = mk(0, 1, 1, 0, 32'h1100,32'h1104,0, 0,   0, 0, 32'hD00, 2, 1, 1, 8, 4);
        tbl[32] = mk(0, 1, 0, 0, 32'h0,   32'h0,   1, 1,   1, 0, 32'hD00, 1, 1, 1, 9, 4);
        tbl[33] = mk(0, 1, 0, 0, 32'h0,   32'h0,   1, 1,   1, 1, 32'h1100,0, 1, 1, 10, 5);
        // Reset with entries pending and sticky flags set.
        tbl[34] = mk(0, 1, 1, 1, 32'h40,  32'h44,  0, 0,   0, 0, 32'h1100,1, 1, 1, 10, 5);
        tbl[35] = mk(0, 1, 1, 1, 32'h50,  32'h54,  0, 0,   0, 0, 32'h1100,2, 1, 1, 10, 5);
        tbl[36] = mk(1, 1, 1, 1, 32'h60,  32'h64,  1, 0,   0, 0, 32'h0,   0, 0, 0, 0, 0);
        tbl[37] = mk(0, 1, 0, 0, 32'h0,   32'h0,   0, 0,   0, 0, 32'h0,   0, 0, 0, 0, 0);

        for (int i = 0; i < 38; i++) begin
            apply(tbl[i], i);
        end

        // Hand sequence: fill with 1,1,0,1, extra push dropped, then resolve
        // in order; the last one mispredicts and must use entry 3's fallthrough.
        apply(mk(0, 1, 1, 1, 32'h2000, 32'h2004, 0, 0, 0, 0, 32'h0,    1, 0, 0, 0, 0), 100);
        apply(mk(0, 1, 1, 1, 32'h2100, 32'h2104, 0, 0, 0, 0, 32'h0,    2, 0, 0, 0, 0), 101);
        apply(mk(0, 1, 1, 0, 32'h2200, 32'h2204, 0, 0, 0, 0, 32'h0,    3, 0, 0, 0, 0), 102);
        apply(mk(0, 1, 1, 1, 32'h2300, 32'h2304, 0, 0, 0, 0, 32'h0,    4, 0, 0, 0, 0), 103);
        apply(mk(0, 1, 1, 0, 32'h2400, 32'h2404, 0, 0, 0, 0, 32'h0,    4, 1, 0, 0, 0), 104);
        apply(mk(0, 1, 0, 0, 32'h0,    32'h0,    1, 1, 1, 0, 32'h0,    3, 1, 0, 1, 0), 105);
        apply(mk(0, 1, 0, 0, 32'h0,    32'h0,    1, 1, 1, 0, 32'h0,    2, 1, 0, 2, 0), 106);
        apply(mk(0, 1, 0, 0, 32'h0,    32'h0,    1, 0, 1, 0, 32'h0,    1, 1, 0, 3, 0), 107);
        apply(mk(0, 1, 0, 0, 32'h0,    32'h0,    1, 0, 1, 1, 32'h2304, 0, 1, 0, 4, 1), 108);
        apply(mk(0, 1, 0, 0, 32'h0,    32'h0,    1, 0, 0, 0, 32'h2304, 0, 1, 1, 4, 1), 109);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
